uart_rx_deser: RTL and testbench
================================

Name: uart_rx_deser

Overview:
Parametrised UART receive deserialiser: successor to the fixed 10-bit receive shift register. Sits between the rx oversampling/bit-timing logic, which supplies mid-bit samples with a `sample_done` strobe, and the receive FIFO or host.
- Tracks frame position itself with an internal FSM; no external `shift` control.
- Supports 5–9 data bits, optional odd/even parity, and 1 or 2 stop bits.
- Delivers data with a valid/ready handshake plus parity, framing and overrun status.

Parameters:
DATA_BITS, 8, data bits per frame, legal 5..9
PARITY_MODE, 0, 0 = none, 1 = odd, 2 = even
STOP_BITS, 1, stop bits checked, legal 1 or 2
LSB_FIRST, 1, 1 = first received data bit lands in data_out[0]; 0 = first bit lands in data_out[DATA_BITS-1]

Ports:
clk  in  1  system clock, all logic on rising edge
reset  in  1  synchronous, active-high reset
rx_in  in  1  sampled serial line value, meaningful only when sample_done = 1
sample_done  in  1  one-cycle strobe, one per bit period at mid-bit
enable  in  1  receiver enable; low forces FSM to IDLE
data_out  out  DATA_BITS  last committed data word
data_valid  out  1  data_out and status flags are valid
data_ready  in  1  consumer accepts the word when data_valid & data_ready
parity_err  out  1  parity mismatch on the word in data_out (always 0 when PARITY_MODE = 0)
frame_err  out  1  a stop sample was 0 on the word in data_out
overrun  out  1  sticky: a frame completed while data_valid & !data_ready
busy  out  1  FSM not in IDLE

Behaviour:
- Reset values: all outputs 0, FSM in IDLE, bit counter 0, shift register 0. Reset has priority over every other input, including mid-frame.
- FSM states: IDLE, DATA, PARITY, STOP. All transitions are qualified by sample_done = 1 && enable = 1; without both, state and counters hold.
- IDLE -> DATA when rx_in = 0 (start bit); the counter clears. When rx_in = 1, stay in IDLE.
- DATA: shift rx_in into the shift register and increment the counter.
  - Shift direction: right-shift when LSB_FIRST = 1, left-shift otherwise.
  - After the DATA_BITS-th sample, go to PARITY if PARITY_MODE != 0, else to STOP; the counter clears.
- PARITY: capture the parity bit and go to STOP.
  - Odd: error if XOR(data, parity bit) = 0.
  - Even: error if XOR(data, parity bit) = 1.
- STOP: any stop sample equal to 0 sets an internal stop-error bit. After STOP_BITS samples, commit and go to IDLE.
- Commit: on the clock edge of the final stop sample, the following update together:
  - data_out, parity_err and frame_err are loaded; data_valid = 1.
  - Latency: data_valid asserts in the cycle after the final stop strobe.
  - A word with errors is still delivered, with its flags set.
- Handshake:
  - data_valid & data_ready clears data_valid on the next edge.
  - data_out and the flags are held stable while data_valid = 1.
- Commit and handshake on the same edge: the old word is consumed, the new word is loaded, data_valid stays 1, and no overrun occurs.
- Commit while data_valid & !data_ready:
  - The new word is dropped; data_out and the flags keep the old word.
  - overrun is set to 1.
  - overrun clears only on the next successful handshake edge or on reset.
- enable = 0: the FSM returns to IDLE on the next edge and the partial frame is discarded. The output register, data_valid and overrun are unaffected, so the handshake still works while disabled.
- After a stop error the FSM still returns to IDLE. A line held low re-triggers a start on the next sample.
- busy = (state != IDLE).

Optional Feature:
Macro: UART_RX_BREAK_DETECT_EN.
- When defined:
  - Adds output port break_det (1 bit, reset 0).
  - A frame in which every sample from start bit through the last stop bit is 0 commits with break_det = 1, frame_err = 0, parity_err = 0, data_out = 0.
  - The FSM then waits in an extra state, BREAK, until a sample with rx_in = 1, then returns to IDLE.
  - break_det follows the same valid/hold/clear rules as the other flags.
- When undefined: no port and no BREAK state; an all-zero frame is reported as frame_err = 1 with data_out = 0.

Test Plan:
- Defaults (8N1): send 0xA5, LSB first, one sample_done every 16 clocks -> data_valid 1 cycle after the stop strobe; data_out = 0xA5; parity_err = 0; frame_err = 0; busy low after commit.
- PARITY_MODE = 1: send 0x03 with parity bit 0 -> parity_err = 1, data_out = 0x03. Repeat with parity bit 1 -> parity_err = 0.
- Stop sample 0 on 0x3C -> frame_err = 1, data_out = 0x3C; the following frame 0x11 decodes cleanly after the line returns high.
- Hold data_ready = 0 across two frames 0x12 then 0x34 -> data_out remains 0x12, overrun = 1. Pulse data_ready -> data_valid = 0 and overrun = 0 on the same edge.
- Drop enable after 4 data bits, re-enable, then send 0x5A -> only 0x5A is delivered, with no error flags. Separately, assert reset mid-frame -> all outputs 0, FSM in IDLE.
- DATA_BITS = 7, PARITY_MODE = 2, STOP_BITS = 2, LSB_FIRST = 0: send 0x41 with correct even parity, second stop bit 0 -> data_out = 7'h41, frame_err = 1, parity_err = 0.

Source files
------------

// File: rtl/uart_rx_deser.sv
// UART receive deserialiser: start/data/parity/stop framing with valid/ready output and status.
// Optional break detection is compiled in with UART_RX_BREAK_DETECT_EN.
module uart_rx_deser #(
    parameter int unsigned DATA_BITS   = 8,
    parameter int unsigned PARITY_MODE = 0,
    parameter int unsigned STOP_BITS   = 1,
    parameter int unsigned LSB_FIRST   = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 rx_in,
    input  logic                 sample_done,
    input  logic                 enable,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 data_valid,
    input  logic                 data_ready,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 overrun,
    output logic                 busy
`ifdef UART_RX_BREAK_DETECT_EN
    ,
    output logic                 break_det
`endif
);

    localparam logic [3:0] LastData = 4'(DATA_BITS - 1);
    localparam logic [3:0] LastStop = 4'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        StIdle,
        StData,
        StParity,
        StStop
`ifdef UART_RX_BREAK_DETECT_EN
        ,
        StBreak
`endif
    } state_e;

    state_e               state_q, state_d;
    logic [3:0]           cnt_q, cnt_d;
    logic [DATA_BITS-1:0] shreg_q, shreg_d, shifted;
    logic                 par_err_q, par_err_d;
    logic                 stop_err_q, stop_err_d;
    logic                 par_calc;
    logic                 commit;
    logic [DATA_BITS-1:0] commit_data;
    logic                 commit_perr, commit_ferr;
    logic                 handshake;

    logic [DATA_BITS-1:0] data_q;
    logic                 valid_q, perr_q, ferr_q, ovr_q;

`ifdef UART_RX_BREAK_DETECT_EN
    logic zero_q, zero_d;
    logic commit_brk;
    logic brk_q;
`endif

    generate
        if (LSB_FIRST != 0) begin : g_lsb_first
            assign shifted = {rx_in, shreg_q[DATA_BITS-1:1]};
        end else begin : g_msb_first
            assign shifted = {shreg_q[DATA_BITS-2:0], rx_in};
        end
    endgenerate

    assign par_calc = (^shreg_q) ^ rx_in;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        shreg_d    = shreg_q;
        par_err_d  = par_err_q;
        stop_err_d = stop_err_q;
        commit     = 1'b0;
`ifdef UART_RX_BREAK_DETECT_EN
        zero_d     = zero_q;
`endif
        if (!enable) begin
            state_d = StIdle;
        end else if (sample_done) begin
            unique case (state_q)
                StIdle: begin
                    if (!rx_in) begin
                        state_d    = StData;
                        cnt_d      = '0;
                        par_err_d  = 1'b0;
                        stop_err_d = 1'b0;
`ifdef UART_RX_BREAK_DETECT_EN
                        zero_d     = 1'b1;
`endif
                    end
                end
                StData: begin
                    shreg_d = shifted;
                    cnt_d   = cnt_q + 4'd1;
`ifdef UART_RX_BREAK_DETECT_EN
                    zero_d  = zero_q & ~rx_in;
`endif
                    if (cnt_q == LastData) begin
                        cnt_d   = '0;
                        state_d = (PARITY_MODE != 0) ? StParity : StStop;
                    end
                end
                StParity: begin
                    // Odd parity flags an even total; even parity flags an odd total.
                    par_err_d = (PARITY_MODE == 1) ? ~par_calc : par_calc;
                    state_d   = StStop;
`ifdef UART_RX_BREAK_DETECT_EN
                    zero_d    = zero_q & ~rx_in;
`endif
                end
                StStop: begin
                    if (!rx_in) stop_err_d = 1'b1;
                    cnt_d = cnt_q + 4'd1;
`ifdef UART_RX_BREAK_DETECT_EN
                    zero_d = zero_q & ~rx_in;
`endif
                    if (cnt_q == LastStop) begin
                        commit  = 1'b1;
                        cnt_d   = '0;
                        state_d = StIdle;
`ifdef UART_RX_BREAK_DETECT_EN
                        if (zero_q && !rx_in) state_d = StBreak;
`endif
                    end
                end
`ifdef UART_RX_BREAK_DETECT_EN
                StBreak: begin
                    if (rx_in) state_d = StIdle;
                end
`endif
                default: state_d = StIdle;
            endcase
        end
    end

    // The final stop sample is folded in directly since it is not yet registered.
    always_comb begin
        commit_data = shreg_q;
        commit_perr = par_err_q;
        commit_ferr = stop_err_q | ~rx_in;
`ifdef UART_RX_BREAK_DETECT_EN
        commit_brk  = zero_q & ~rx_in;
        if (commit_brk) begin
            commit_data = '0;
            commit_perr = 1'b0;
            commit_ferr = 1'b0;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            shreg_q    <= '0;
            par_err_q  <= 1'b0;
            stop_err_q <= 1'b0;
`ifdef UART_RX_BREAK_DETECT_EN
            zero_q     <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            shreg_q    <= shreg_d;
            par_err_q  <= par_err_d;
            stop_err_q <= stop_err_d;
`ifdef UART_RX_BREAK_DETECT_EN
            zero_q     <= zero_d;
`endif
        end
    end

    assign handshake = valid_q & data_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            data_q  <= '0;
            valid_q <= 1'b0;
            perr_q  <= 1'b0;
            ferr_q  <= 1'b0;
            ovr_q   <= 1'b0;
`ifdef UART_RX_BREAK_DETECT_EN
            brk_q   <= 1'b0;
`endif
        end else if (commit && (!valid_q || data_ready)) begin
            data_q  <= commit_data;
            valid_q <= 1'b1;
            perr_q  <= commit_perr;
            ferr_q  <= commit_ferr;
`ifdef UART_RX_BREAK_DETECT_EN
            brk_q   <= commit_brk;
`endif
            if (handshake) ovr_q <= 1'b0;
        end else if (commit) begin
            // Consumer still holds the old word: drop the new one.
            ovr_q <= 1'b1;
        end else if (handshake) begin
            valid_q <= 1'b0;
            ovr_q   <= 1'b0;
        end
    end

    assign data_out   = data_q;
    assign data_valid = valid_q;
    assign parity_err = perr_q;
    assign frame_err  = ferr_q;
    assign overrun    = ovr_q;
    assign busy       = (state_q != StIdle);
`ifdef UART_RX_BREAK_DETECT_EN
    assign break_det  = brk_q;
`endif

endmodule

// File: tb/tb_uart_rx_deser.sv
// Bench for uart_rx_deser: three configurations (8N1, 8O1, 7E2 MSB-first) against a frame-level
// model with directed literal checks and randomized frames, ready and enable drops.
module tb_uart_rx_deser;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic [2:0] rx = 3'b111;
    logic [2:0] sd = 3'b000;
    logic [2:0] en = 3'b111;
    logic [2:0] rdy = 3'b000;
    wire  [7:0] dout0, dout1;
    wire  [6:0] dout2;
    wire  [2:0] dv, pe, fe, ov, bz;

    uart_rx_deser u0 (
        .clk(clk), .reset(reset), .rx_in(rx[0]), .sample_done(sd[0]), .enable(en[0]),
        .data_out(dout0), .data_valid(dv[0]), .data_ready(rdy[0]), .parity_err(pe[0]),
        .frame_err(fe[0]), .overrun(ov[0]), .busy(bz[0])
    );
    uart_rx_deser #(.PARITY_MODE(1)) u1 (
        .clk(clk), .reset(reset), .rx_in(rx[1]), .sample_done(sd[1]), .enable(en[1]),
        .data_out(dout1), .data_valid(dv[1]), .data_ready(rdy[1]), .parity_err(pe[1]),
        .frame_err(fe[1]), .overrun(ov[1]), .busy(bz[1])
    );
    uart_rx_deser #(.DATA_BITS(7), .PARITY_MODE(2), .STOP_BITS(2), .LSB_FIRST(0)) u2 (
        .clk(clk), .reset(reset), .rx_in(rx[2]), .sample_done(sd[2]), .enable(en[2]),
        .data_out(dout2), .data_valid(dv[2]), .data_ready(rdy[2]), .parity_err(pe[2]),
        .frame_err(fe[2]), .overrun(ov[2]), .busy(bz[2])
    );

    int n_cmp = 0;
    int n_fail = 0;
    bit chk_on = 1'b0;
    bit rand_rdy = 1'b0;

    function automatic int dbits(input int i);
        return (i == 2) ? 7 : 8;
    endfunction
    function automatic int pmode(input int i);
        return (i == 0) ? 0 : ((i == 1) ? 1 : 2);
    endfunction
    function automatic int sbits(input int i);
        return (i == 2) ? 2 : 1;
    endfunction
    function automatic bit lsbf(input int i);
        return (i != 2);
    endfunction
    function automatic logic [8:0] dout_of(input int i);
        if (i == 0) return {1'b0, dout0};
        if (i == 1) return {1'b0, dout1};
        return {2'b00, dout2};
    endfunction

    // Frame-level model: expected word of the frame whose last stop strobe is being driven.
    bit         c_pend [3];
    logic [8:0] c_data [3];
    bit         c_pe   [3];
    bit         c_fe   [3];
    logic [8:0] m_data [3];
    bit         m_valid[3];
    bit         m_pe   [3];
    bit         m_fe   [3];
    bit         m_ov   [3];

    always @(posedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (reset) begin
                m_data[i]  <= '0;
                m_valid[i] <= 1'b0;
                m_pe[i]    <= 1'b0;
                m_fe[i]    <= 1'b0;
                m_ov[i]    <= 1'b0;
            end else if (c_pend[i]) begin
                if (!m_valid[i] || rdy[i]) begin
                    m_data[i]  <= c_data[i];
                    m_pe[i]    <= c_pe[i];
                    m_fe[i]    <= c_fe[i];
                    m_valid[i] <= 1'b1;
                    if (m_valid[i]) m_ov[i] <= 1'b0;
                end else begin
                    m_ov[i] <= 1'b1;
                end
            end else if (m_valid[i] && rdy[i]) begin
                m_valid[i] <= 1'b0;
                m_ov[i]    <= 1'b0;
            end
        end
    end

    task automatic cmpb(input string nm, input int i, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s[%0d] t=%0t got %b want %b", nm, i, $time, act, exp);
        end
    endtask
    task automatic cmpd(input string nm, input int i, input logic [8:0] act, input logic [8:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s[%0d] t=%0t got %h want %h", nm, i, $time, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (chk_on) begin
            for (int i = 0; i < 3; i++) begin
                cmpb("valid", i, dv[i], m_valid[i]);
                cmpb("overrun", i, ov[i], m_ov[i]);
                if (m_valid[i]) begin
                    cmpd("data", i, dout_of(i), m_data[i]);
                    cmpb("parity_err", i, pe[i], m_pe[i]);
                    cmpb("frame_err", i, fe[i], m_fe[i]);
                end
            end
        end
    end

    always begin
        @(posedge clk);
        #1;
        if (rand_rdy) begin
            for (int i = 0; i < 3; i++) rdy[i] = ($urandom % 3 != 0);
        end
    end

    // Called and returns at posedge+1.
    task automatic strobe(input int i, input bit b, input bit last, input int gap);
        sd[i] = 1'b0;
        repeat (gap) begin
            rx[i] = 1'($urandom);
            @(posedge clk);
            #1;
        end
        rx[i] = b;
        sd[i] = 1'b1;
        c_pend[i] = last;
        @(posedge clk);
        #1;
        sd[i] = 1'b0;
        c_pend[i] = 1'b0;
        rx[i] = 1'($urandom);
    endtask

    // abort_kind 1 drops enable, 2 pulses reset, before strobe index abort_at.
    task automatic send_frame(input int i, input logic [8:0] data, input bit par,
                              input logic [1:0] stops, input int gap, input int abort_at,
                              input int abort_kind);
        logic [15:0] bv;
        logic [8:0]  d;
        int          n;
        int          db;
        int          g;
        db = dbits(i);
        n  = 0;
        bv = '0;
        d  = data & 9'((1 << db) - 1);
        bv[n] = 1'b0;
        n++;
        for (int k = 0; k < db; k++) begin
            bv[n] = lsbf(i) ? d[k] : d[db-1-k];
            n++;
        end
        if (pmode(i) != 0) begin
            bv[n] = par;
            n++;
        end
        for (int k = 0; k < sbits(i); k++) begin
            bv[n] = stops[k];
            n++;
        end
        c_data[i] = d;
        c_pe[i]   = (pmode(i) == 0) ? 1'b0 :
                    ((pmode(i) == 1) ? ~((^d) ^ par) : ((^d) ^ par));
        c_fe[i]   = (sbits(i) == 1) ? !stops[0] : !(stops[0] && stops[1]);
        for (int k = 0; k < n; k++) begin
            if (k == abort_at) begin
                cmpb("busy_mid", i, bz[i], 1'b1);
                if (abort_kind == 1) begin
                    en[i] = 1'b0;
                    sd[i] = 1'b1;
                    rx[i] = 1'b0;
                    @(posedge clk);
                    #1;
                    sd[i] = 1'b0;
                    repeat (1 + $urandom % 3) begin
                        @(posedge clk);
                        #1;
                    end
                    cmpb("busy_disabled", i, bz[i], 1'b0);
                    en[i] = 1'b1;
                end else begin
                    reset = 1'b1;
                    @(posedge clk);
                    #1;
                    reset = 1'b0;
                end
                return;
            end
            g = (gap >= 0) ? gap : int'($urandom % 4);
            strobe(i, bv[k], k == n - 1, g);
        end
    endtask

    task automatic consume(input int i);
        rdy[i] = 1'b1;
        @(posedge clk);
        #1;
        rdy[i] = 1'b0;
    endtask

    task automatic check_word(input string nm, input int i, input logic [8:0] d,
                              input bit p, input bit f);
        cmpb({nm, "_valid"}, i, dv[i], 1'b1);
        cmpd({nm, "_data"}, i, dout_of(i), d);
        cmpb({nm, "_perr"}, i, pe[i], p);
        cmpb({nm, "_ferr"}, i, fe[i], f);
        cmpb({nm, "_busy"}, i, bz[i], 1'b0);
    endtask

    initial begin
        for (int i = 0; i < 3; i++) c_pend[i] = 1'b0;
        @(posedge clk);
        #1;
        chk_on = 1'b1;
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        for (int i = 0; i < 3; i++) begin
            cmpb("rst_valid", i, dv[i], 1'b0);
            cmpb("rst_perr", i, pe[i], 1'b0);
            cmpb("rst_ferr", i, fe[i], 1'b0);
            cmpb("rst_ovr", i, ov[i], 1'b0);
            cmpb("rst_busy", i, bz[i], 1'b0);
            cmpd("rst_data", i, dout_of(i), 9'h000);
        end
        reset = 1'b0;

        // 8N1 0xA5 at one strobe per 16 clocks
        send_frame(0, 9'h0A5, 1'b0, 2'b11, 15, -1, 0);
        check_word("a5", 0, 9'h0A5, 1'b0, 1'b0);
        consume(0);
        cmpb("a5_consumed", 0, dv[0], 1'b0);

        // Odd parity
        send_frame(1, 9'h003, 1'b0, 2'b11, -1, -1, 0);
        check_word("odd_bad", 1, 9'h003, 1'b1, 1'b0);
        consume(1);
        send_frame(1, 9'h003, 1'b1, 2'b11, -1, -1, 0);
        check_word("odd_good", 1, 9'h003, 1'b0, 1'b0);
        consume(1);

        // Stop error then a clean frame
        send_frame(0, 9'h03C, 1'b0, 2'b10, -1, -1, 0);
        check_word("stop0", 0, 9'h03C, 1'b0, 1'b1);
        consume(0);
        strobe(0, 1'b1, 1'b0, 2);
        strobe(0, 1'b1, 1'b0, 2);
        send_frame(0, 9'h011, 1'b0, 2'b11, -1, -1, 0);
        check_word("after_stop0", 0, 9'h011, 1'b0, 1'b0);
        consume(0);

        // All-zero frame without break detection
        send_frame(0, 9'h000, 1'b0, 2'b00, -1, -1, 0);
        check_word("allzero", 0, 9'h000, 1'b0, 1'b1);
        consume(0);

        // Overrun
        send_frame(0, 9'h012, 1'b0, 2'b11, -1, -1, 0);
        send_frame(0, 9'h034, 1'b0, 2'b11, -1, -1, 0);
        cmpd("ovr_data", 0, dout_of(0), 9'h012);
        cmpb("ovr_set", 0, ov[0], 1'b1);
        consume(0);
        cmpb("ovr_hs_valid", 0, dv[0], 1'b0);
        cmpb("ovr_hs_clear", 0, ov[0], 1'b0);

        // Enable drop after 4 data bits, then 0x5A
        send_frame(0, 9'h0FF, 1'b0, 2'b11, -1, 5, 1);
        strobe(0, 1'b1, 1'b0, 1);
        send_frame(0, 9'h05A, 1'b0, 2'b11, -1, -1, 0);
        check_word("after_dis", 0, 9'h05A, 1'b0, 1'b0);
        consume(0);
        cmpb("after_dis_single", 0, dv[0], 1'b0);

        // Reset mid-frame with a held word and overrun pending
        send_frame(0, 9'h077, 1'b0, 2'b11, -1, -1, 0);
        send_frame(0, 9'h078, 1'b0, 2'b11, -1, -1, 0);
        send_frame(0, 9'h05C, 1'b0, 2'b11, -1, 4, 2);
        cmpb("rstmid_valid", 0, dv[0], 1'b0);
        cmpb("rstmid_ovr", 0, ov[0], 1'b0);
        cmpb("rstmid_busy", 0, bz[0], 1'b0);
        cmpd("rstmid_data", 0, dout_of(0), 9'h000);

        // 7E2 MSB first
        send_frame(2, 9'h041, 1'b0, 2'b01, -1, -1, 0);
        check_word("e7_41", 2, 9'h041, 1'b0, 1'b1);
        consume(2);
        send_frame(2, 9'h003, 1'b0, 2'b11, -1, -1, 0);
        check_word("e7_03", 2, 9'h003, 1'b0, 1'b0);
        consume(2);

        // Randomized frames
        rand_rdy = 1'b1;
        for (int i = 0; i < 3; i++) begin
            repeat (40) begin
                logic [8:0] d;
                logic [1:0] st;
                bit         p;
                int         ab;
                d  = 9'($urandom);
                p  = 1'($urandom);
                st = ($urandom % 6 == 0) ? 2'($urandom) : 2'b11;
                ab = ($urandom % 10 == 0) ? int'(1 + $urandom % 12) : -1;
                if ($urandom % 15 == 0) begin
                    d  = '0;
                    p  = 1'b0;
                    st = 2'b00;
                end
                repeat ($urandom % 3) strobe(i, 1'b1, 1'b0, int'($urandom % 3));
                send_frame(i, d, p, st, -1, ab, 1);
            end
        end
        rand_rdy = 1'b0;
        #2;
        rdy = 3'b111;
        repeat (5) begin
            @(posedge clk);
            #1;
        end
        for (int i = 0; i < 3; i++) cmpb("drained", i, dv[i], 1'b0);
        chk_on = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
